// File: rtl/logic_pipe_if.sv
// rtl/logic_pipe_if.sv - stream/handshake bundle for logic_pipe; Q_par present with LOGIC_PIPE_PARITY_EN
interface logic_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       Mode;
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] Q;
  logic             Out_valid;
  logic             Out_ready;
  logic [CNT_W-1:0] Xfer_cnt;
`ifdef LOGIC_PIPE_PARITY_EN
  logic             Q_par;

  modport master (
    output A, B, Mode, In_valid, Out_ready,
    input  In_ready, Q, Out_valid, Xfer_cnt, Q_par
  );
  modport slave (
    input  A, B, Mode, In_valid, Out_ready,
    output In_ready, Q, Out_valid, Xfer_cnt, Q_par
  );
`else
  modport master (
    output A, B, Mode, In_valid, Out_ready,
    input  In_ready, Q, Out_valid, Xfer_cnt
  );
  modport slave (
    input  A, B, Mode, In_valid, Out_ready,
    output In_ready, Q, Out_valid, Xfer_cnt
  );
`endif
endinterface

// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - selectable bitwise function into an elastic STAGES-deep register pipe
// LOGIC_PIPE_PARITY_EN adds an even-parity bit carried alongside the data to Q_par.
module logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input logic         Clk,
  input logic         Rst_n,
  logic_pipe_if.slave bus
);
  logic [WIDTH-1:0]  fn_result;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ready;
  logic [CNT_W-1:0]  xfer_q;
  logic              tail_full;

  always_comb begin
    fn_result = '0;
    case (bus.Mode)
      2'b00:   fn_result = ~((bus.A & bus.B) | bus.B);
      2'b01:   fn_result = bus.A & bus.B;
      2'b10:   fn_result = bus.A | bus.B;
      default: fn_result = bus.A ^ bus.B;
    endcase
  end

  // Stage i is blocked only when it and every stage after it are full and the sink stalls.
  always_comb begin
    ready     = '0;
    tail_full = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      tail_full = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        tail_full = tail_full & valid_q[j];
      end
      ready[i] = !tail_full || bus.Out_ready;
    end
  end

  // Data registers only capture valid beats, so bubbles never disturb a held Q.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_q <= '0;
      xfer_q  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (ready[0]) begin
        valid_q[0] <= bus.In_valid;
        if (bus.In_valid) begin
          data_q[0] <= fn_result;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (ready[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
      if (valid_q[STAGES-1] && bus.Out_ready) begin
        xfer_q <= xfer_q + CNT_W'(1);
      end
    end
  end

  assign bus.In_ready  = ready[0];
  assign bus.Q         = data_q[STAGES-1];
  assign bus.Out_valid = valid_q[STAGES-1];
  assign bus.Xfer_cnt  = xfer_q;

`ifdef LOGIC_PIPE_PARITY_EN
  logic [STAGES-1:0] par_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      par_q <= '0;
    end else begin
      if (ready[0] && bus.In_valid) begin
        par_q[0] <= ^fn_result;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (ready[i] && valid_q[i-1]) begin
          par_q[i] <= par_q[i-1];
        end
      end
    end
  end

  assign bus.Q_par = par_q[STAGES-1];
`endif
endmodule

// File: tb/tb_logic_pipe.sv
// tb/tb_logic_pipe.sv - directed vector bench for logic_pipe (WIDTH=8, STAGES=3, CNT_W=4)
module tb_logic_pipe;
  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic       par;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   idx;
  vec_t vec [10];

  logic_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

  logic_pipe #(.WIDTH(8), .STAGES(3), .CNT_W(4)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v);
    bus.A        = vec[n].a;
    bus.B        = vec[n].b;
    bus.Mode     = vec[n].mode;
    bus.In_valid = v;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.In_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    vec[0] = '{2'b00, 8'hF0, 8'hCC, 8'h33, 1'b0};
    vec[1] = '{2'b01, 8'hF0, 8'hCC, 8'hC0, 1'b0};
    vec[2] = '{2'b10, 8'hF0, 8'hCC, 8'hFC, 1'b0};
    vec[3] = '{2'b11, 8'hF0, 8'hCC, 8'h3C, 1'b0};
    vec[4] = '{2'b00, 8'h00, 8'h00, 8'hFF, 1'b0};
    vec[5] = '{2'b01, 8'hFF, 8'hAA, 8'hAA, 1'b0};
    vec[6] = '{2'b10, 8'h12, 8'h40, 8'h52, 1'b1};
    vec[7] = '{2'b11, 8'hFF, 8'h55, 8'hAA, 1'b0};
    vec[8] = '{2'b00, 8'hA5, 8'h0F, 8'hF0, 1'b0};
    vec[9] = '{2'b11, 8'h01, 8'h00, 8'h01, 1'b1};

    // Reset with random activity on the inputs.
    rst_n         = 1'b0;
    bus.Out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.A        = 8'($urandom);
      bus.B        = 8'($urandom);
      bus.Mode     = 2'($urandom);
      bus.In_valid = 1'($urandom);
      tick();
    end
    chk("rst_q", 32'(bus.Q), 0);
    chk("rst_out_valid", 32'(bus.Out_valid), 0);
    chk("rst_xfer_cnt", 32'(bus.Xfer_cnt), 0);
    chk("rst_in_ready", 32'(bus.In_ready), 1);
`ifdef LOGIC_PIPE_PARITY_EN
    chk("rst_q_par", 32'(bus.Q_par), 0);
`endif
    bus.In_valid = 1'b0;
    rst_n        = 1'b1;
    tick();

    // Streaming table: one beat per cycle, result three edges after capture.
    for (int k = 0; k < 12; k++) begin
      if (k < 10) drive(k, 1'b1);
      else bus.In_valid = 1'b0;
      tick();
      if (k >= 2) begin
        chk("fn_q", 32'(bus.Q), 32'(vec[k-2].q));
        chk("fn_out_valid", 32'(bus.Out_valid), 1);
`ifdef LOGIC_PIPE_PARITY_EN
        chk("fn_q_par", 32'(bus.Q_par), 32'(vec[k-2].par));
`endif
      end
    end
    tick();
    chk("fn_xfer_cnt", 32'(bus.Xfer_cnt), 10);
    chk("fn_drained", 32'(bus.Out_valid), 0);

    // Backpressure: five beats offered into a stalled three-deep pipe.
    do_reset();
    bus.Out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      drive(idx, 1'b1);
      #1;
      chk("bp_in_ready", 32'(bus.In_ready), 32'(idx < 3));
      tick();
      if (idx < 3) idx++;
      if (k >= 2) begin
        chk("bp_q_hold", 32'(bus.Q), 32'(vec[0].q));
        chk("bp_out_valid", 32'(bus.Out_valid), 1);
      end
    end
    bus.Out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (idx < 5) drive(idx, 1'b1);
      else bus.In_valid = 1'b0;
      #1;
      chk("bp_drain_q", 32'(bus.Q), 32'(vec[c].q));
      chk("bp_drain_valid", 32'(bus.Out_valid), 1);
      chk("bp_drain_in_ready", 32'(bus.In_ready), 1);
      tick();
      if (idx < 5) idx++;
    end
    chk("bp_empty", 32'(bus.Out_valid), 0);
    chk("bp_xfer_cnt", 32'(bus.Xfer_cnt), 5);

    // Bubble collapse behind a stalled head beat.
    do_reset();
    bus.Out_ready = 1'b0;
    drive(5, 1'b1);
    tick();
    bus.In_valid = 1'b0;
    tick();
    tick();
    chk("bub_head_valid", 32'(bus.Out_valid), 1);
    chk("bub_head_q", 32'(bus.Q), 32'(vec[5].q));
    for (int k = 6; k < 8; k++) begin
      drive(k, 1'b1);
      #1;
      chk("bub_in_ready", 32'(bus.In_ready), 1);
      tick();
    end
    bus.In_valid = 1'b0;
    #1;
    chk("bub_full_in_ready", 32'(bus.In_ready), 0);
    chk("bub_q_hold", 32'(bus.Q), 32'(vec[5].q));
    bus.Out_ready = 1'b1;
    for (int c = 5; c < 8; c++) begin
      #1;
      chk("bub_drain_q", 32'(bus.Q), 32'(vec[c].q));
      tick();
    end
    chk("bub_xfer_cnt", 32'(bus.Xfer_cnt), 3);
    chk("bub_empty", 32'(bus.Out_valid), 0);

    // Counter wrap at 2^4, then reset with beats in flight.
    do_reset();
    bus.Out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(k % 10, 1'b1);
      tick();
    end
    bus.In_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("wrap_xfer_cnt", 32'(bus.Xfer_cnt), 1);
    chk("wrap_empty", 32'(bus.Out_valid), 0);
    drive(0, 1'b1);
    tick();
    drive(1, 1'b1);
    tick();
    bus.In_valid = 1'b0;
    tick();
    chk("rst2_pre_valid", 32'(bus.Out_valid), 1);
    rst_n = 1'b0;
    tick();
    chk("rst2_xfer_cnt", 32'(bus.Xfer_cnt), 0);
    chk("rst2_q", 32'(bus.Q), 0);
    chk("rst2_out_valid", 32'(bus.Out_valid), 0);
    chk("rst2_in_ready", 32'(bus.In_ready), 1);
`ifdef LOGIC_PIPE_PARITY_EN
    chk("rst2_q_par", 32'(bus.Q_par), 0);
`endif
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("rst2_discarded", 32'(bus.Out_valid), 0);
    chk("rst2_no_count", 32'(bus.Xfer_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined successor to the single-flop gate/DFF timing path. It computes one of four selectable bitwise logic functions on WIDTH-bit operands, then registers the result through STAGES pipeline registers. Each stage has a per-stage valid bit and valid/ready backpressure with bubble collapse, and the block counts completed output transfers. It is the standard multi-stage, multi-bit registered path for static-timing characterisation runs.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits, ≥1
- STAGES, 3: number of pipeline register stages, ≥1
- CNT_W, 16: width of the transfer counter, ≥1

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  reset, synchronous, active-low
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Mode  input  2  function select, sampled with the input beat
- In_valid  input  1  input beat valid
- In_ready  output  1  block can accept an input beat
- Q  output  WIDTH  result at the last stage
- Out_valid  output  1  Q valid
- Out_ready  input  1  downstream accepts Q
- Xfer_cnt  output  CNT_W  count of completed output transfers
- Q_par  output  1  even parity of Q; present only with LOGIC_PIPE_PARITY_EN

## Operation
- Function is evaluated combinationally on input and captured into stage 0:
  - Mode 00: ~((A & B) | B), the legacy path function
  - Mode 01: A & B
  - Mode 10: A | B
  - Mode 11: A ^ B
- Stages 0..STAGES-1 each hold a data register and a valid bit. Q and Out_valid are the last stage's registers.
- Ready chain:
  - ready[STAGES] = Out_ready
  - ready[i] = !valid[i] || ready[i+1]
  - In_ready = ready[0]
- Stage i loads when ready[i]:
  - stage 0 loads data = f(A,B,Mode) and valid = In_valid
  - stage i>0 loads data and valid from stage i-1
- Stalled stages hold their data and valid bit. Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- Input accept happens when In_valid && In_ready. Output transfer happens when Out_valid && Out_ready.
- On each output transfer, Xfer_cnt increments by 1 and wraps modulo 2^CNT_W, with no saturation and no flag.
- Data in a stage whose valid bit is 0 is don't-care, but it must not change Q while Out_valid=0 and Out_ready=0.

## Timing
- Latency is STAGES cycles. A beat accepted at edge n appears with Out_valid=1 after edge n+STAGES-1, provided no stall.
- Throughput is one beat per cycle when Out_ready is held 1.
- In_ready is combinational from Out_ready and the valid bits. There is no combinational path from A, B, Mode or In_valid to any output.
- Reset, at a rising edge with Rst_n=0:
  - all valid bits 0, all data registers 0, Q=0, Out_valid=0, Xfer_cnt=0
  - In_ready=1 once reset releases
  - Q_par=0
- Reset mid-operation discards all in-flight beats. No transfer is counted on the reset edge, even if Out_ready=1.
- When the pipeline is full and Out_ready=0, In_ready=0 and In_valid is ignored.
- Simultaneous accept and transfer on a full pipeline is legal: every stage shifts and occupancy is unchanged.
- Downstream must treat Out_valid as sticky until the transfer completes. The block never drops Out_valid without a transfer, except on reset.

## Configuration
- LOGIC_PIPE_PARITY_EN defined:
  - Q_par port exists and carries the registered even parity of the stage data, so that XOR of Q and Q_par is 0.
  - Parity is computed at stage 0 and pipelined alongside the data.
  - Q_par has the same latency and stall behaviour as Q.
- LOGIC_PIPE_PARITY_EN undefined:
  - Q_par port and its registers are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold Rst_n=0 for 2 cycles with random inputs, then release.
  - Q=0, Out_valid=0, Xfer_cnt=0, In_ready=1.
- Functions (WIDTH=8, STAGES=3, Out_ready=1): drive A=0xF0, B=0xCC with Mode 00,01,10,11 on consecutive cycles.
  - Q on cycles 3..6 is 0x33, 0xC0, 0xFC, 0x3C.
- Backpressure:
  - Stream 5 beats with Out_ready=0: In_ready drops after 3 accepts and Q holds the first result.
  - Raise Out_ready: all 5 results emerge in order and Xfer_cnt=5.
- Bubble collapse: inject 1 beat, hold Out_ready=0 until it reaches the last stage, then send 2 more.
  - Both are accepted and In_ready stays 1 until 3 stages are valid.
- Wrap and reset: with CNT_W=4, complete 17 transfers.
  - Xfer_cnt=1.
  - Assert Rst_n=0 with 2 beats in flight: no extra transfer, and all outputs return to reset values.
- Parity, with LOGIC_PIPE_PARITY_EN: A=0x01, B=0x00, Mode 11.
  - Q=0x01 and Q_par=1.
  - Same vectors without the macro: Q_par port absent, Q unchanged.
